mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS execute stage, alongside the ALU. Takes the same A/B operands from the register file and computes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers. The control unit stalls on Busy; mfhi/mflo read HI/LO through the write-back mux.

## Interface
- WIDTH, 32: operand width; HI/LO are WIDTH each.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- Start  input  1  launch request, sampled each rising edge.
- MDOperation  input  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- A  input  WIDTH  multiplicand / dividend; also the data for mthi/mtlo.
- B  input  WIDTH  multiplier / divisor.
- WriteHI  input  1  mthi: HI <= A.
- WriteLO  input  1  mtlo: LO <= A.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: HI/LO updated by the last operation.
- DivByZero  output  1  last divide had B == 0; held until the next accepted Start.
- HI  output  WIDTH  product[63:32] or remainder.
- LO  output  WIDTH  product[31:0] or quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, Start=1: latch operands and op, clear DivByZero.
  - DIV or DIVU with B==0: set DivByZero. Go to FIX with no iterations. HI/LO stay unchanged.
  - Otherwise: load the iteration counter with 32 and go to CALC.
- Signed ops (MULT, DIV): operands converted to magnitudes at launch. Result sign is applied in FIX.
  - Product sign is A[31]^B[31].
  - Quotient sign is A[31]^B[31]. Remainder sign is A[31].
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle. Remainder is WIDTH+1 bits internally.
- CALC exits to FIX after exactly 32 iterations.
- FIX: apply two's-complement negation where required, write HI/LO, pulse Done, go to IDLE.
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No exception is raised.
- WriteHI/WriteLO take effect only in IDLE when Start=0. They are ignored while Busy, and also when Start is accepted in the same cycle.
- WriteHI and WriteLO together both write A.
- Start while Busy: ignored, with no queuing.

## Timing
- Reset (reset=0 at a rising edge) forces:
  - state IDLE;
  - HI=0, LO=0;
  - Busy=0, Done=0, DivByZero=0.
- Reset mid-operation aborts the operation. No Done is produced.
- Normal op, Start accepted at edge E0:
  - Busy=1 from after E0 through E33.
  - CALC iterations happen at E1..E32; FIX at E33.
  - After E33: HI/LO hold the result, Done=1 for one cycle, Busy=0.
- Divide by zero, accepted at E0: Busy=1 for one cycle. At E1, Done=1 and DivByZero=1; HI/LO are unchanged.
- Busy and Done are never high together.
- Start may be reasserted in the Done cycle. It is accepted at the next edge.
- mthi/mtlo: HI or LO is updated at the edge where it is sampled and visible the next cycle.
- HI and LO are registered outputs, stable except at FIX, at an mthi/mtlo write, or at reset.

## Test plan
- MULT A=0xFFFFFFFF, B=0x00000002 -> Done 34 cycles after Start. HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=0x0000000E, HI=0x00000002.
- DIVU A=5, B=0 with HI/LO preloaded to 0x11111111/0x22222222 by mthi/mtlo -> Done one cycle after the accepting edge. DivByZero=1, HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Then a second Start in the Done cycle -> accepted, and Busy rises next cycle.
- MULT 3×4 in flight: Start (B=9) and WriteLO asserted at cycle 10 -> both ignored. Final HI=0, LO=0x0000000C.
- Reset low at cycle 15 of a DIV -> after that edge, Busy=0, HI=LO=0, no Done pulse. A following MULTU 0x10000×0x10000 -> HI=0x00000001, LO=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, sign fixup at the end.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MDOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WriteHI,
    input  logic             WriteLO,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, next_state;
    logic   accept;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    is_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]        a_mag, b_mag;

    logic [CNT_W-1:0]   cnt;
    logic               op_div, neg_q, neg_r;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvsr;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_bit;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    // Launch-time operand conditioning: signed ops work on magnitudes
    assign a_s       = A;
    assign b_s       = B;
    assign is_signed = ~MDOperation[0];
    assign a_neg     = is_signed && (a_s < 0);
    assign b_neg     = is_signed && (b_s < 0);
    assign a_mag     = cneg_w(A, a_neg);
    assign b_mag     = cneg_w(B, b_neg);
    assign b_zero    = (B == '0);

    // Multiply step: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? dvsr : '0)};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: low half of acc shifts dividend out and quotient in
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, dvsr};
    assign div_bit   = ~div_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    next_state = (MDOperation[1] && b_zero) ? FIX : CALC;
                end
            end
            CALC:    if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            dvsr   <= b_mag;
            rem    <= '0;
            op_div <= MDOperation[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= CNT_W'(WIDTH);
        end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
            if (op_div) begin
                rem              <= div_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_bit};
            end else begin
                acc <= mul_next;
            end
        end
    end

    // Architectural results and status
    always_ff @(posedge clk) begin
        if (!reset) begin
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= (state == FIX);
            if (accept) DivByZero <= MDOperation[1] && b_zero;
            if (state == FIX) begin
                if (!DivByZero) begin
                    if (op_div) begin
                        LO <= cneg_w(acc[WIDTH-1:0], neg_q);
                        HI <= cneg_w(rem, neg_r);
                    end else begin
                        {HI, LO} <= cneg_2w(acc, neg_q);
                    end
                end
            end else if (state == IDLE && !Start) begin
                if (WriteHI) HI <= A;
                if (WriteLO) LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, timing, mthi/mtlo, divide-by-zero and reset abort.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOperation;
    logic [31:0] A, B;
    logic        WriteHI, WriteLO;
    logic        Busy, Done, DivByZero;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic done_seen;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOperation(MDOperation),
        .A(A), .B(B), .WriteHI(WriteHI), .WriteLO(WriteLO),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for Done; cnt counts edges including the accepting one
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cnt);
        Start = 1'b1; MDOperation = op; A = a; B = b;
        step();
        Start = 1'b0;
        cnt = 1;
        chk("busy_launch", {31'b0, Busy}, 32'd1);
        while (!Done && cnt < 100) begin
            chk("busy_done_excl", {31'b0, Busy & Done}, 32'd0);
            step();
            cnt++;
        end
        chk("done_reached", {31'b0, Done}, 32'd1);
        chk("busy_at_done", {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; Start = 1'b0; MDOperation = 2'b00; A = '0; B = '0;
        WriteHI = 1'b0; WriteLO = 1'b0;
        step(); step();
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_dbz", {31'b0, DivByZero}, 32'd0);
        reset = 1'b1;
        step();

        // MULT -1 * 2
        run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, cyc);
        chk("mult_latency", cyc, 32'd34);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFE);
        step();
        chk("done_pulse", {31'b0, Done}, 32'd0);

        // MULTU same operands
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, cyc);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);
        step();

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, cyc);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        chk("div_dbz", {31'b0, DivByZero}, 32'd0);
        step();

        // DIVU 100 / 7
        run_op(2'b11, 32'd100, 32'd7, cyc);
        chk("divu_lo", LO, 32'h0000000E);
        chk("divu_hi", HI, 32'h00000002);
        step();

        // mthi + mtlo together, then separately
        A = 32'h5A5A5A5A; WriteHI = 1'b1; WriteLO = 1'b1;
        step();
        WriteHI = 1'b0; WriteLO = 1'b0;
        chk("mt_both_hi", HI, 32'h5A5A5A5A);
        chk("mt_both_lo", LO, 32'h5A5A5A5A);
        A = 32'h11111111; WriteHI = 1'b1;
        step();
        WriteHI = 1'b0;
        A = 32'h22222222; WriteLO = 1'b1;
        step();
        WriteLO = 1'b0;
        chk("mthi", HI, 32'h11111111);
        chk("mtlo", LO, 32'h22222222);

        // DIVU by zero
        run_op(2'b11, 32'd5, 32'd0, cyc);
        chk("dbz_latency", cyc, 32'd2);
        chk("dbz_flag", {31'b0, DivByZero}, 32'd1);
        chk("dbz_hi", HI, 32'h11111111);
        chk("dbz_lo", LO, 32'h22222222);
        step();
        chk("dbz_held", {31'b0, DivByZero}, 32'd1);
        chk("dbz_done_pulse", {31'b0, Done}, 32'd0);

        // DIV overflow case, then restart in the Done cycle
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc);
        chk("ovf_lo", LO, 32'h80000000);
        chk("ovf_hi", HI, 32'h00000000);
        chk("ovf_dbz_clr", {31'b0, DivByZero}, 32'd0);
        run_op(2'b01, 32'd3, 32'd5, cyc);
        chk("b2b_latency", cyc, 32'd34);
        chk("b2b_lo", LO, 32'h0000000F);
        chk("b2b_hi", HI, 32'h00000000);
        step();

        // MULT 3*4 with Start and WriteLO injected mid-operation
        Start = 1'b1; MDOperation = 2'b00; A = 32'd3; B = 32'd4;
        step();
        Start = 1'b0;
        cyc = 1;
        repeat (9) begin step(); cyc++; end
        Start = 1'b1; B = 32'd9; A = 32'hDEADBEEF; WriteLO = 1'b1;
        step(); cyc++;
        Start = 1'b0; WriteLO = 1'b0;
        chk("inject_busy", {31'b0, Busy}, 32'd1);
        chk("inject_lo", LO, 32'h0000000F);
        while (!Done && cyc < 100) begin step(); cyc++; end
        chk("inject_latency", cyc, 32'd34);
        chk("inject_hi", HI, 32'h00000000);
        chk("inject_res_lo", LO, 32'h0000000C);
        step();

        // Reset mid-DIV
        Start = 1'b1; MDOperation = 2'b10; A = 32'd1000; B = 32'd3;
        step();
        Start = 1'b0;
        repeat (14) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        chk("abort_done", {31'b0, Done}, 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            step();
            if (Done) done_seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, done_seen}, 32'd0);

        run_op(2'b01, 32'h00010000, 32'h00010000, cyc);
        chk("post_rst_hi", HI, 32'h00000001);
        chk("post_rst_lo", LO, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
